// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb
//  Purpose  : Two-port arbiter in front of a single-port synchronous SRAM.
//             Requester 0 is the labeling engine and requester 1 is the host
//             readout. Grants are combinational in the request cycle. Ties
//             are resolved round-robin, and the current owner may hold the
//             SRAM with a bounded lock. The SRAM command is registered, and
//             read data returns two cycles after acceptance.
//  Ports    : clk, reset (async, active-low)
//             req0/1, wen0/1 (0=write), a0/1[AW], d0/1[DW], lock0/1  - requests
//             gnt0/1                 - combinational accept strobes
//             rdata[DW], rvalid0/1   - registered read return
//             sram_a[AW], sram_d[DW], sram_wen (active-low) - registered SRAM cmd
//             sram_q[DW]             - SRAM read data for the address on sram_a
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arb #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wen0,
    input  logic          wen1,
    input  logic [AW-1:0] a0,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic          sram_wen,
    input  logic [DW-1:0] sram_q
);

    localparam int              c_CW  = $clog2(MAX_LOCK + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          r_state_q,  w_state_d;
    logic            r_last_q,   w_last_d;    // last winner: 0 or 1
    logic            r_lock_q,   w_lock_d;    // last grant was a locked grant
    logic [c_CW-1:0] r_lcnt_q,   w_lcnt_d;
    logic [AW-1:0]   r_sram_a_q, w_sram_a_d;
    logic [DW-1:0]   r_sram_d_q, w_sram_d_d;
    logic            r_wen_q,    w_wen_d;
    logic            r_rpend_q,  w_rpend_d;   // read on the SRAM bus this cycle
    logic            r_rid_q,    w_rid_d;     // requester owning that read
    logic [DW-1:0]   r_rdata_q,  w_rdata_d;
    logic            r_rv0_q,    w_rv0_d;
    logic            r_rv1_q,    w_rv1_d;

    logic w_hold0, w_hold1, w_gnt0, w_gnt1;

    // Arbitration
    always_comb begin
        // An owner keeps priority only when its previous grant was locked and
        // it has not yet used up its MAX_LOCK allowance. Once the allowance
        // is exhausted, round-robin hands the SRAM to the other side, because
        // the owner is also the last winner.
        w_hold0 = (r_state_q == OWN0) && r_lock_q && (r_lcnt_q < c_MAX);
        w_hold1 = (r_state_q == OWN1) && r_lock_q && (r_lcnt_q < c_MAX);
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        if (req0 && req1) begin
            if (w_hold0)       w_gnt0 = 1'b1;
            else if (w_hold1)  w_gnt1 = 1'b1;
            else if (r_last_q) w_gnt0 = 1'b1;
            else               w_gnt1 = 1'b1;
        end else if (req0) begin
            w_gnt0 = 1'b1;
        end else if (req1) begin
            w_gnt1 = 1'b1;
        end
    end

    // Next-state and datapath
    always_comb begin
        w_state_d  = w_gnt0 ? OWN0 : (w_gnt1 ? OWN1 : IDLE);
        w_last_d   = w_gnt0 ? 1'b0 : (w_gnt1 ? 1'b1 : r_last_q);
        w_lock_d   = (w_gnt0 && lock0) || (w_gnt1 && lock1);
        w_lcnt_d   = '0;
        if (w_lock_d) begin
            // A locked grant continues the run only for the same owner.
            // A new owner, or a grant coming out of IDLE, starts at one.
            if (w_state_d == r_state_q)
                w_lcnt_d = (r_lcnt_q == c_MAX) ? c_MAX : r_lcnt_q + c_CW'(1);
            else
                w_lcnt_d = c_CW'(1);
        end

        w_sram_a_d = '0;
        w_sram_d_d = '0;
        w_wen_d    = 1'b1;
        if (w_gnt0) begin
            w_sram_a_d = a0;
            w_sram_d_d = d0;
            w_wen_d    = wen0;
        end else if (w_gnt1) begin
            w_sram_a_d = a1;
            w_sram_d_d = d1;
            w_wen_d    = wen1;
        end
        w_rpend_d  = (w_gnt0 && wen0) || (w_gnt1 && wen1);
        w_rid_d    = w_gnt1;

        // sram_q is valid while the read address sits on sram_a
        w_rdata_d  = r_rpend_q ? sram_q : r_rdata_q;
        w_rv0_d    = r_rpend_q && !r_rid_q;
        w_rv1_d    = r_rpend_q &&  r_rid_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q  <= IDLE;
            r_last_q   <= 1'b1;
            r_lock_q   <= 1'b0;
            r_lcnt_q   <= '0;
            r_sram_a_q <= '0;
            r_sram_d_q <= '0;
            r_wen_q    <= 1'b1;
            r_rpend_q  <= 1'b0;
            r_rid_q    <= 1'b0;
            r_rdata_q  <= '0;
            r_rv0_q    <= 1'b0;
            r_rv1_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_last_q   <= w_last_d;
            r_lock_q   <= w_lock_d;
            r_lcnt_q   <= w_lcnt_d;
            r_sram_a_q <= w_sram_a_d;
            r_sram_d_q <= w_sram_d_d;
            r_wen_q    <= w_wen_d;
            r_rpend_q  <= w_rpend_d;
            r_rid_q    <= w_rid_d;
            r_rdata_q  <= w_rdata_d;
            r_rv0_q    <= w_rv0_d;
            r_rv1_q    <= w_rv1_d;
        end
    end

    // Grants are forced low while reset is asserted, whatever the requests
    assign gnt0     = w_gnt0 & reset;
    assign gnt1     = w_gnt1 & reset;
    assign rdata    = r_rdata_q;
    assign rvalid0  = r_rv0_q;
    assign rvalid1  = r_rv1_q;
    assign sram_a   = r_sram_a_q;
    assign sram_d   = r_sram_d_q;
    assign sram_wen = r_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arb
//  Purpose  : Directed self-checking bench for sram_arb with a behavioural
//             SRAM and a read-return scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arb;

    localparam int AW       = 10;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 8;

    logic          clk;
    logic          reset;
    logic          req0, req1, wen0, wen1, lock0, lock1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          gnt0, gnt1, rvalid0, rvalid1, sram_wen;
    logic [DW-1:0] rdata, sram_d, sram_q;
    logic [AW-1:0] sram_a;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sb[$];

    int            checks = 0;
    int            errors = 0;
    int            cyc_n  = 0;
    logic [AW-1:0] e_a    = '0;
    logic [DW-1:0] e_d    = '0;
    logic          e_wen  = 1'b1;

    sram_arb #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .a0(a0), .a1(a1), .d0(d0), .d1(d1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen),
        .sram_q(sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: read data follows the address combinationally
    assign sram_q = sram_mem[sram_a];
    always @(posedge clk) if (!sram_wen) sram_mem[sram_a] <= sram_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive this cycle's inputs,
    // check the combinational grants, then model the resulting command.
    task automatic cyc(input logic rn,
                       input logic r0, input logic w0, input logic l0,
                       input logic [AW-1:0] ad0, input logic [DW-1:0] dd0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] ad1, input logic [DW-1:0] dd1,
                       input logic eg0, input logic eg1);
        rd_t e;
        @(negedge clk);
        chk("sram_a", 32'(sram_a), 32'(e_a));
        chk("sram_d", 32'(sram_d), 32'(e_d));
        chk("sram_wen", 32'(sram_wen), 32'(e_wen));
        if (sb.size() != 0 && sb[0].due == cyc_n) begin
            e = sb.pop_front();
            chk("rvalid0", 32'(rvalid0), 32'(!e.id));
            chk("rvalid1", 32'(rvalid1), 32'(e.id));
            chk("rdata", 32'(rdata), 32'(e.data));
        end else begin
            chk("rvalid_idle", 32'({rvalid0, rvalid1}), 32'd0);
        end
        reset = rn;
        req0 = r0; wen0 = w0; lock0 = l0; a0 = ad0; d0 = dd0;
        req1 = r1; wen1 = w1; lock1 = l1; a1 = ad1; d1 = dd1;
        if (!rn) sb.delete();
        #1;
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        e_a = '0; e_d = '0; e_wen = 1'b1;
        if (rn && eg0) begin
            e_a = ad0; e_d = dd0; e_wen = w0;
            if (w0) sb.push_back('{cyc_n + 2, 1'b0, ref_mem[ad0]});
            else    ref_mem[ad0] = dd0;
        end else if (rn && eg1) begin
            e_a = ad1; e_d = dd1; e_wen = w1;
            if (w1) sb.push_back('{cyc_n + 2, 1'b1, ref_mem[ad1]});
            else    ref_mem[ad1] = dd1;
        end
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = DW'(i * 7 + 3);
            ref_mem[i]  = DW'(i * 7 + 3);
        end
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wen0 = 1'b1; wen1 = 1'b1;
        lock0 = 1'b0; lock1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;

        // Reset held with both requesting: no grants, idle bus
        for (int k = 0; k < 2; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0);
        chk("rdata_rst", 32'(rdata), 32'd0);

        // Tie of reads straight out of reset: 0, 1, 0
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b1, 1'b0, 10'd6, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b1, 1'b0, 10'd6, '0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b1, 1'b0, 10'd6, '0, 1'b1, 1'b0);
        idle(3);

        // Single requester write, then read back by the other requester
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'd33, 8'h05, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 10'd33, '0, 1'b0, 1'b1);
        // Top address boundary: write 0xFF to 1023, then read it back
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 10'd1023, 8'hFF, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd1023, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        // Make requester 1 the last winner ahead of the lock run
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 10'd100, '0, 1'b0, 1'b1);
        idle(1);

        // Lock: requester 0 keeps MAX_LOCK grants, then the lock breaks
        for (int k = 0; k < MAX_LOCK; k++)
            cyc(1'b1, 1'b1, 1'b1, 1'b1, AW'(200 + k), '0, 1'b1, 1'b1, 1'b0, 10'd300, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'd250, '0, 1'b1, 1'b1, 1'b0, 10'd300, '0, 1'b0, 1'b1);
        // Alternation resumes once the lock is released
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd251, '0, 1'b1, 1'b1, 1'b0, 10'd301, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd252, '0, 1'b1, 1'b1, 1'b0, 10'd302, '0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd253, '0, 1'b1, 1'b1, 1'b0, 10'd303, '0, 1'b1, 1'b0);

        // A locked owner that drops its request loses the lock
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'd400, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'd401, '0, 1'b1, 1'b1, 1'b0, 10'd402, '0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'd403, '0, 1'b1, 1'b1, 1'b0, 10'd404, '0, 1'b1, 1'b0);
        idle(3);

        // Reset during an in-flight read: the read must never return
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 10'd8, '0, 1'b1, 1'b1, 1'b0, 10'd9, '0, 1'b0, 1'b0);
        // First tie after release goes to requester 0, then alternates
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd8, '0, 1'b1, 1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd10, '0, 1'b1, 1'b1, 1'b0, 10'd11, '0, 1'b0, 1'b1);
        idle(4);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 The module SHALL have parameter AW, default 10, meaning the SRAM address width (1024 x 8 label map).
REQ-002 The module SHALL have parameter DW, default 8, meaning the SRAM data width.
REQ-003 The module SHALL have parameter MAX_LOCK, default 8, meaning the maximum consecutive locked grants while the other requester waits.
REQ-004 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The ports SHALL be as follows:
  clk  input  1  rising-edge clock
  reset  input  1  asynchronous reset, active-low (asserted at 0)
  req0, req1  input  1 each  access request (0 = labeling engine, 1 = host readout)
  wen0, wen1  input  1 each  0 = write, 1 = read (SRAM polarity)
  a0, a1  input  AW each  request address
  d0, d1  input  DW each  write data
  lock0, lock1  input  1 each  keep ownership for the next request; qualified by reqX
  gnt0, gnt1  output  1 each  request accepted this cycle (combinational)
  rdata  output  DW  read return data (registered)
  rvalid0, rvalid1  output  1 each  one-cycle pulse marking rdata for requester X
  sram_a  output  AW  SRAM address (registered)
  sram_d  output  DW  SRAM write data (registered)
  sram_wen  output  1  SRAM write enable, active-low (registered)
  sram_q  input  DW  SRAM read data, valid in the cycle its address is driven

Function
REQ-006 A transfer SHALL occur in cycle t when reqX=1 and gntX=1; at most one gnt SHALL be high per cycle; gnt SHALL never be high without its req.
REQ-007 State SHALL be tracked as IDLE / OWN0 / OWN1, plus a 1-bit last-winner register and a lock counter of ceil(log2(MAX_LOCK+1)) bits.
REQ-008 Single requester: that requester SHALL be granted in the same cycle, with no bubble.
REQ-009 Both requesting, no valid lock: the requester that is not the last winner SHALL win (round-robin).
REQ-010 Lock: if the current owner was granted with lockX=1 and requests again, it SHALL win over the other requester while lock count < MAX_LOCK.
  - Lock count SHALL increment per locked grant and clear on ownership change or on an unlocked grant.
  - At count = MAX_LOCK with the other requester waiting, the lock SHALL be broken and the other requester granted.
REQ-011 Transitions:
  - IDLE -> OWNX on grant to X.
  - OWNX -> OWNY on grant to Y.
  - OWNX -> IDLE in a cycle with no req.
REQ-012 An accepted command in cycle t SHALL appear on sram_a/sram_d/sram_wen at t+1. With no command, sram_wen=1, sram_a=0, sram_d=0 in the next cycle.
REQ-013 For a read accepted at t, rdata SHALL be sram_q sampled at the end of t+1, with rvalidX=1 during t+2 only (read latency 2). Back-to-back reads SHALL return in order, one per cycle.
REQ-014 A write SHALL produce no rvalid; a write followed by a read of the same address SHALL return the new data.
REQ-015 Width rules: addresses pass unmodified, with no wrap or arithmetic on a/d; AW and DW SHALL be honoured on all buses.
REQ-016 Simultaneous events: a request from the non-owner is evaluated in the same cycle the owner drops req; the owner dropping req SHALL also void its lock.

Reset
REQ-017 While reset=0, the block SHALL hold:
  - state=IDLE, last-winner=1 (so requester 0 wins the first tie), lock count=0
  - sram_a=0, sram_d=0, sram_wen=1
  - rdata=0, rvalid0=rvalid1=0
  - gnt0=gnt1=0 regardless of req
REQ-018 Reset asserted mid-operation SHALL discard in-flight reads: no rvalid after release. The first cycle after release SHALL arbitrate from the reset state.

Verification
REQ-019 Single-requester path: req0=1, wen0=0, a0=10'd33, d0=8'h05 at t -> gnt0=1 at t; sram_a=33, sram_d=5, sram_wen=0 at t+1; no rvalid.
REQ-020 Tie: req0=req1=1 reads from reset -> gnt0 at t, gnt1 at t+1, gnt0 at t+2 (alternating); rvalid0 at t+2, rvalid1 at t+3.
REQ-021 Lock break: MAX_LOCK=8, req0=lock0=1 continuous, req1=1 from t -> gnt0 for 8 cycles, gnt1 on the 9th, then alternation resumes.
REQ-022 Write then read of address 1023 with data 8'hFF -> rdata=8'hFF with rvalid at acceptance+2.
REQ-023 Reset pulled low one cycle after a read is accepted, released 3 cycles later -> rvalid stays 0 throughout; sram_wen=1; first tie after release grants requester 0.
